// File: rtl/serial_parity_pkg.sv
// ---------------------------------------------------------------------------
// serial_parity_pkg
// Definitions shared by the serial parity receiver and transmitter:
//   rx_state_t  - frame FSM states (IDLE, DATA, PARITY, STOP)
//   PAR_EVEN    - parity select value for even parity
//   PAR_ODD     - parity select value for odd parity
//   IDLE_LEVEL  - level of the serial line when no frame is in flight
// ---------------------------------------------------------------------------
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam bit PAR_EVEN   = 1'b0;
    localparam bit PAR_ODD    = 1'b1;
    localparam bit IDLE_LEVEL = 1'b1;

endpackage : serial_parity_pkg

// File: rtl/parity_accum.sv
// ---------------------------------------------------------------------------
// parity_accum
// One-bit running XOR register, shared between the parity receiver and
// transmitter.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset, clears the accumulator
//   clr   - synchronous clear (takes priority over en)
//   en    - when high, din is XORed into the accumulator
//   din   - data bit to fold in
//   acc   - current XOR of all bits folded in since the last clear
// ---------------------------------------------------------------------------
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic acc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule : parity_accum

// File: rtl/serial_parity_rx.sv
// ---------------------------------------------------------------------------
// serial_parity_rx
// Receives one serial frame per transfer: start bit (low), DATA_W data bits
// LSB first, one parity bit, one stop bit (high). The line is sampled only
// on cycles where bit_en is high.
// Parameters:
//   DATA_W     - data bits per frame (1..32)
//   PARITY_ODD - PAR_EVEN (0) or PAR_ODD (1)
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset
//   bit_en     - one-cycle strobe, one per bit period; rx_in sampled here
//   rx_in      - serial line, idle high
//   data_out   - last successfully received word, held between frames
//   data_valid - one-cycle pulse after a frame with a high stop bit
//   parity_err - parity result of the last good frame, held
//   frame_err  - one-cycle pulse after a frame whose stop bit was low
//   busy       - high while a frame is in progress
// ---------------------------------------------------------------------------
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    // One extra bit so the counter can reach DATA_W without wrapping.
    localparam int CNT_W = $clog2(DATA_W) + 1;

    rx_state_t         state_q;
    rx_state_t         state_d;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              perr_q;
    logic              acc;
    logic              start_bit;
    logic              last_bit;
    logic              acc_en;

    assign start_bit = bit_en && (state_q == IDLE) && (rx_in != IDLE_LEVEL);
    assign last_bit  = (cnt_q == CNT_W'(DATA_W - 1));
    assign acc_en    = bit_en && (state_q == DATA);
    assign busy      = (state_q != IDLE);

    parity_accum u_parity_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_bit),
        .en    (acc_en),
        .din   (rx_in),
        .acc   (acc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only advances on bit_en. A low stop bit returns to IDLE
    // and is not reinterpreted as a start bit.
    always_comb begin
        state_d = state_q;
        if (bit_en) begin
            case (state_q)
                IDLE:    if (rx_in != IDLE_LEVEL) state_d = DATA;
                DATA:    if (last_bit)            state_d = PARITY;
                PARITY:                           state_d = STOP;
                STOP:                             state_d = IDLE;
                default:                          state_d = IDLE;
            endcase
        end
    end

    // Place the incoming bit at position cnt_q (LSB first).
    always_comb begin
        shreg_d = shreg_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                shreg_d[i] = rx_in;
            end
        end
    end

    // Datapath and status outputs. Pulses clear on every edge, bit_en or not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            cnt_q      <= '0;
            perr_q     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (bit_en) begin
                case (state_q)
                    IDLE: begin
                        if (rx_in != IDLE_LEVEL) begin
                            shreg_q <= '0;
                            cnt_q   <= '0;
                        end
                    end
                    DATA: begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                    PARITY: begin
                        perr_q <= ((acc ^ rx_in) != PARITY_ODD);
                    end
                    STOP: begin
                        if (rx_in) begin
                            data_out   <= shreg_q;
                            parity_err <= perr_q;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule : serial_parity_rx
